// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the data-memory path:
// funct3 access codes, responder states, alignment helper.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_state_t;

  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] addr
  );
    logic mis;
    mis = 1'b0;
    if (funct3[1:0] == 2'b01) mis = addr[0];
    if (funct3[1:0] == 2'b10) mis = (addr != 2'b00);
    return mis;
  endfunction

  function automatic logic is_illegal_f3(
    input logic       we,
    input logic [2:0] funct3
  );
    logic bad;
    if (we) bad = (funct3 != F3_B) && (funct3 != F3_H) &&
                  (funct3 != F3_W);
    else    bad = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                  (funct3 == 3'b111);
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_load_extend.sv
// Load lane select with sign/zero extension.
// Purely combinational so a cache can reuse it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    data_o   = 32'h0;
    unique case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    unique case (funct3_i)
      F3_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:  data_o = {{16{half_sel[15]}}, half_sel};
      F3_W:  data_o = word_i;
      F3_BU: data_o = {24'h0, byte_sel};
      F3_HU: data_o = {16'h0, half_sel};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: one request at a time,
// optional wait states, byte-lane stores, extended loads.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall_mem
);

  localparam int AW    = ADDR_BITS + 2;
  localparam int DEPTH = 1 << ADDR_BITS;

  dmem_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_BITS-1:0] widx;
  logic [31:0] rd_word;
  logic [31:0] ld_data;
  logic        wr_req;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        req_bad;
  logic        unused_addr;

  // Upper address bits are ignored so accesses wrap.
  assign unused_addr = ^req_addr[31:AW];

  assign widx    = addr_q[AW-1:2];
  assign rd_word = mem_q[widx];
  assign req_bad = is_illegal_f3(req_we, req_funct3) |
                   is_misaligned(req_funct3, req_addr[1:0]);

  load_extend u_ext (
    .word_i   (rd_word),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    wr_be   = 4'b1111;
    wr_data = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    wr_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          cnt_d   = 4'(WAIT_CYCLES);
          if (req_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          if (we_q) wr_req = 1'b1;
          else      rsp_rdata_d = ld_data;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset at the commit edge still wins over the store.
  assign wr_en = wr_req & ~reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem_q[widx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      f3_q        <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign stall_mem = req_valid & ~rsp_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed spec cases on two
// instances (0 and 3 wait states) plus randomized traffic.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rv0 = 1'b0;
  logic        rv1 = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;

  logic        vld0, err0, stl0;
  logic [31:0] rd0;
  logic        vld1, err1, stl1;
  logic [31:0] rd1;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mdl [2][4096];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(rv0),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(err0),
    .stall_mem(stl0)
  );

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(rv1),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(vld1), .rsp_rdata(rd1), .rsp_err(err1),
    .stall_mem(stl1)
  );

  // Byte-addressed reference memory; 4 KiB image wraps.
  task automatic model(input int d, input logic we,
                       input logic [31:0] addr,
                       input logic [31:0] wdata,
                       input logic [2:0] f3,
                       output logic [31:0] er,
                       output logic ee);
    int size;
    int a;
    logic illegal;
    longint v;
    size = 1 << f3[1:0];
    a = int'(addr & 32'hFFF);
    if (we) illegal = (f3 > 3'd2);
    else illegal = (f3 == 3'd3) || (f3 > 3'd5);
    ee = illegal || ((a % size) != 0);
    er = 32'h0;
    if (ee) return;
    if (we) begin
      for (int i = 0; i < size; i++)
        mdl[d][a+i] = 8'(wdata >> (8*i));
    end else begin
      v = 0;
      for (int i = 0; i < size; i++)
        v = v | (longint'(mdl[d][a+i]) << (8*i));
      if (!f3[2] && size < 4 && v[8*size-1])
        v = v - (64'sd1 << (8*size));
      er = v[31:0];
    end
  endtask

  // Caller is #1 after a posedge; returns #1 after the
  // posedge that ends the response cycle.
  task automatic do_req(input int d, input logic we,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [2:0] f3,
                        output logic [31:0] rdata,
                        output logic err,
                        output int lat,
                        output int stl);
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_funct3 = f3;
    if (d == 0) rv0 = 1'b1; else rv1 = 1'b1;
    lat = -1;
    stl = 0;
    rdata = 32'hx;
    err = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((d == 0) ? stl0 : stl1) stl++;
      if ((d == 0) ? vld0 : vld1) begin
        lat = k;
        rdata = (d == 0) ? rd0 : rd1;
        err = (d == 0) ? err0 : err1;
        break;
      end
    end
    @(posedge clk); #1;
    rv0 = 1'b0;
    rv1 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rv0 = 1'b1;
    rv1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({vld0, vld1, err0, err1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0000",
               {vld0, vld1, err0, err1});
    end
    n_checks++;
    if ({rd0, rd1} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rdata got %h/%h want 0", rd0, rd1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    rv0 = 1'b0;
    rv1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({vld0, vld1, stl0, stl1} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_prio got %b want 0000",
                 {vld0, vld1, stl0, stl1});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_rw;
    logic [31:0] r, er;
    logic e, ee;
    int lat, stl;
    model(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, er, ee);
    do_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, r, e, lat, stl);
    n_checks++;
    if ({lat, stl} !== {32'd2, 32'd2} || r !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_word got lat=%0d stall=%0d rd=%h err=%b want 2 2 0 0",
               lat, stl, r, e);
    end
    @(negedge clk);
    n_checks++;
    if (vld0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_one_cycle got %b want 0", vld0);
    end
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h100, 32'h0, 3'b010, r, e, lat, stl);
    n_checks++;
    if ({lat, stl} !== {32'd2, 32'd2} || r !== 32'hDEADBEEF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_word got lat=%0d stall=%0d rd=%h err=%b want 2 2 deadbeef 0",
               lat, stl, r, e);
    end
  endtask

  task automatic test_byte_half;
    logic [31:0] addrs [4] = '{32'h203, 32'h203, 32'h200, 32'h202};
    logic [2:0]  f3s   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080,
                               32'h00007F01, 32'h000080FF};
    logic [31:0] r, er;
    logic e, ee;
    int lat, stl;
    model(0, 1'b1, 32'h200, 32'h80FF7F01, 3'b010, er, ee);
    do_req(0, 1'b1, 32'h200, 32'h80FF7F01, 3'b010, r, e, lat, stl);
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b0, addrs[i], 32'h0, f3s[i], r, e, lat, stl);
      n_checks++;
      if (r !== exps[i] || e !== 1'b0 || lat != 2) begin
        n_fail++;
        $display("FAIL byte_half[%0d] got rd=%h err=%b lat=%0d want %h 0 2",
                 i, r, e, lat, exps[i]);
      end
    end
  endtask

  task automatic test_lane_mask;
    logic [31:0] r, er;
    logic e, ee;
    int lat, stl;
    model(0, 1'b1, 32'h40, 32'h11223344, 3'b010, er, ee);
    do_req(0, 1'b1, 32'h40, 32'h11223344, 3'b010, r, e, lat, stl);
    model(0, 1'b1, 32'h41, 32'hFFFFFFAA, 3'b000, er, ee);
    do_req(0, 1'b1, 32'h41, 32'hFFFFFFAA, 3'b000, r, e, lat, stl);
    model(0, 1'b1, 32'h42, 32'h5555BBCC, 3'b001, er, ee);
    do_req(0, 1'b1, 32'h42, 32'h5555BBCC, 3'b001, r, e, lat, stl);
    do_req(0, 1'b0, 32'h40, 32'h0, 3'b010, r, e, lat, stl);
    n_checks++;
    if (r !== 32'hBBCCAA44 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lane_mask got %h err=%b want bbccaa44 0", r, e);
    end
  endtask

  task automatic test_errors;
    logic [31:0] r;
    logic e;
    int lat, stl;
    do_req(0, 1'b0, 32'h102, 32'h0, 3'b010, r, e, lat, stl);
    n_checks++;
    if (e !== 1'b1 || r !== 32'h0 || lat != 1 || stl != 1) begin
      n_fail++;
      $display("FAIL err_lw_mis got err=%b rd=%h lat=%0d stall=%0d want 1 0 1 1",
               e, r, lat, stl);
    end
    do_req(0, 1'b1, 32'h101, 32'h0000CAFE, 3'b001, r, e, lat, stl);
    n_checks++;
    if (e !== 1'b1 || lat != 1) begin
      n_fail++;
      $display("FAIL err_sh_mis got err=%b lat=%0d want 1 1", e, lat);
    end
    do_req(0, 1'b0, 32'h100, 32'h0, 3'b010, r, e, lat, stl);
    n_checks++;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin
      n_fail++;
      $display("FAIL err_mem_kept got %h want deadbeef", r);
    end
    do_req(0, 1'b0, 32'h100, 32'h0, 3'b011, r, e, lat, stl);
    n_checks++;
    if (e !== 1'b1 || r !== 32'h0 || lat != 1) begin
      n_fail++;
      $display("FAIL err_f3_011 got err=%b rd=%h lat=%0d want 1 0 1",
               e, r, lat);
    end
    do_req(0, 1'b1, 32'h100, 32'h0, 3'b100, r, e, lat, stl);
    n_checks++;
    if (e !== 1'b1 || lat != 1) begin
      n_fail++;
      $display("FAIL err_store_f3 got err=%b lat=%0d want 1 1", e, lat);
    end
  endtask

  task automatic test_wait_abort;
    logic [31:0] r, er;
    logic e, ee;
    int lat, stl;
    model(1, 1'b1, 32'h500, 32'hCAFEF00D, 3'b010, er, ee);
    do_req(1, 1'b1, 32'h500, 32'hCAFEF00D, 3'b010, r, e, lat, stl);
    n_checks++;
    if (lat != 5 || stl != 5 || r !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL wait3_sw got lat=%0d stall=%0d rd=%h err=%b want 5 5 0 0",
               lat, stl, r, e);
    end
    req_we = 1'b1;
    req_addr = 32'h500;
    req_wdata = 32'h0BADBEEF;
    req_funct3 = 3'b010;
    rv1 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (stl1 !== 1'b1 || vld1 !== 1'b0) begin
      n_fail++;
      $display("FAIL wait3_inflight got stall=%b vld=%b want 1 0",
               stl1, vld1);
    end
    reset = 1'b1;
    rv1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (vld1 !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_rsp cycle %0d got %b want 0", k, vld1);
      end
    end
    @(posedge clk); #1;
    do_req(1, 1'b0, 32'h500, 32'h0, 3'b010, r, e, lat, stl);
    n_checks++;
    if (r !== 32'hCAFEF00D || lat != 5) begin
      n_fail++;
      $display("FAIL abort_old_word got %h lat=%0d want cafef00d 5",
               r, lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r, er;
    logic e, ee;
    int lat, stl;
    model(0, 1'b1, 32'h1004, 32'h12345678, 3'b010, er, ee);
    do_req(0, 1'b1, 32'h1004, 32'h12345678, 3'b010, r, e, lat, stl);
    do_req(0, 1'b0, 32'h0004, 32'h0, 3'b010, r, e, lat, stl);
    n_checks++;
    if (r !== 32'h12345678 || lat != 2) begin
      n_fail++;
      $display("FAIL wrap_b2b got %h lat=%0d want 12345678 2", r, lat);
    end
  endtask

  task automatic test_random;
    logic [31:0] r, er, addr, wd;
    logic e, ee, we;
    logic [2:0] f3;
    int lat, stl, wl;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        wd = $urandom;
        model(d, 1'b1, 32'h300 + 4*w, wd, 3'b010, er, ee);
        do_req(d, 1'b1, 32'h300 + 4*w, wd, 3'b010, r, e, lat, stl);
      end
      for (int n = 0; n < 60; n++) begin
        we = 1'($urandom);
        f3 = 3'($urandom_range(0, 7));
        wd = $urandom;
        addr = ($urandom & 32'hFFFFF000) | (32'h300 +
               4*$urandom_range(0, 15) + $urandom_range(0, 3));
        model(d, we, addr, wd, f3, er, ee);
        do_req(d, we, addr, wd, f3, r, e, lat, stl);
        wl = ee ? 1 : (2 + 3*d);
        n_checks++;
        if (r !== er || e !== ee || lat != wl || stl != wl) begin
          n_fail++;
          $display("FAIL rand d%0d we=%b f3=%0d a=%h got rd=%h err=%b lat=%0d st=%0d want %h %b %0d",
                   d, we, f3, addr, r, e, lat, stl, er, ee, wl);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_half();
    test_lane_mask();
    test_errors();
    test_wait_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
